// File: rtl/jk_bank_seq.sv
// jk_bank_seq: command sequencer driving a bank of WIDTH JK cells.
// Host commands arrive on a valid/ready handshake and are turned into per-bit
// J/K drive patterns (clear, set, load, toggle, multi-cycle count).
// Optional: define JKSEQ_DOWN_EN to make opcode 6 a count-down; otherwise it is a NOP.

module jk_bank_seq_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  // Classic JK: hold / clear / set / toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

module jk_bank_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_CLEAR  = 3'd1;
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_LOAD   = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;
  localparam logic [2:0] OP_CUP    = 3'd5;
  localparam logic [2:0] OP_CDN    = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] arg_q;
  logic [CNT_W-1:0] ctr;
  logic [WIDTH-1:0] up_mask;
`ifdef JKSEQ_DOWN_EN
  logic [WIDTH-1:0] dn_mask;
`endif

  function automatic logic is_count(input logic [2:0] op);
`ifdef JKSEQ_DOWN_EN
    return (op == OP_CUP) || (op == OP_CDN);
`else
    return (op == OP_CUP);
`endif
  endfunction

  // Bank of cells; each bit sees its own J/K lane.
  jk_bank_seq_cell u_cell [WIDTH-1:0] (
    .clk  (clk),
    .rst_n(rst_n),
    .j    (j_out),
    .k    (k_out),
    .q    (q)
  );

  // Toggle masks for counting: bit i flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic [WIDTH-1:0] m;
    up_mask = '0;
`ifdef JKSEQ_DOWN_EN
    dn_mask = '0;
`endif
    for (int i = 0; i < WIDTH; i++) begin
      m = (WIDTH'(1) << i) - WIDTH'(1);
      up_mask[i] = ((q & m) == m);
`ifdef JKSEQ_DOWN_EN
      dn_mask[i] = ((q & m) == '0);
`endif
    end
  end

  // J/K drive: active only in APPLY/RUN, decoded from the latched command.
  always_comb begin
    j_out = '0;
    k_out = '0;
    if (state == S_APPLY || state == S_RUN) begin
      case (op_q)
        OP_CLEAR:  k_out = '1;
        OP_SET:    j_out = '1;
        OP_LOAD:   begin j_out = arg_q; k_out = ~arg_q; end
        OP_TOGGLE: begin j_out = arg_q; k_out = arg_q; end
        OP_CUP:    begin j_out = up_mask; k_out = up_mask; end
`ifdef JKSEQ_DOWN_EN
        OP_CDN:    begin j_out = dn_mask; k_out = dn_mask; end
`endif
        default: ;
      endcase
    end
  end

  // Sequencer FSM. ctr holds the remaining q updates; leave for DONE when the
  // update happening on this edge is the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      arg_q     <= '0;
      ctr       <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            arg_q     <= cmd_arg;
            ctr       <= cmd_cnt;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (is_count(cmd_op) && cmd_cnt == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_APPLY;
            end
          end
        end
        S_APPLY: begin
          if (is_count(op_q)) begin
            ctr <= ctr - 1'b1;
            if (ctr == CNT_W'(1)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_RUN: begin
          ctr <= ctr - 1'b1;
          if (ctr == CNT_W'(1)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_seq.sv
// Randomized bench for jk_bank_seq against a command-level reference model.
module tb_jk_bank_seq;
  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [W-1:0]  cmd_arg;
  logic [CW-1:0] cmd_cnt;
  logic [W-1:0]  j_out, k_out, q;
  logic          busy, done;

  int errs = 0;
  int checks = 0;
  logic [W-1:0] mq;

  jk_bank_seq #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_cnt(cmd_cnt),
    .j_out(j_out), .k_out(k_out), .q(q), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef JKSEQ_DOWN_EN
  localparam bit DOWN = 1'b1;
`else
  localparam bit DOWN = 1'b0;
`endif

  function automatic bit counts(input logic [2:0] op);
    return (op == 3'd5) || (DOWN && op == 3'd6);
  endfunction

  // Next bank value for one step of the command.
  function automatic logic [W-1:0] next_q(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] cur);
    case (op)
      3'd1: return '0;
      3'd2: return '1;
      3'd3: return a;
      3'd4: return cur ^ a;
      3'd5: return cur + 1'b1;
      3'd6: return DOWN ? cur - 1'b1 : cur;
      default: return cur;
    endcase
  endfunction

  // Expected J and K for one step.
  function automatic logic [W-1:0] exp_j(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] cur);
    case (op)
      3'd2: return '1;
      3'd3: return a;
      3'd4: return a;
      3'd5: return cur ^ (cur + 1'b1);
      3'd6: return DOWN ? cur ^ (cur - 1'b1) : '0;
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] exp_k(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] cur);
    case (op)
      3'd1: return '1;
      3'd3: return ~a;
      3'd4: return a;
      3'd5: return cur ^ (cur + 1'b1);
      3'd6: return DOWN ? cur ^ (cur - 1'b1) : '0;
      default: return '0;
    endcase
  endfunction

  // Issue one command from a negedge and check every cycle until it retires.
  task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [CW-1:0] n);
    int waitc = 0;
    int steps;
    while (!cmd_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk("ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = a; cmd_cnt = n;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cmd_op = $urandom; cmd_arg = $urandom; cmd_cnt = $urandom;
    steps = counts(op) ? int'(n) : 1;
    for (int t = 1; t <= steps + 1; t++) begin
      @(negedge clk);
      chk("busy", busy, 1);
      chk("ready_busy", cmd_ready, 0);
      chk("done", done, (t == steps + 1));
      chk("q", q, mq);
      if (t <= steps) begin
        chk("j", j_out, exp_j(op, a, mq));
        chk("k", k_out, exp_k(op, a, mq));
        mq = next_q(op, a, mq);
      end else begin
        chk("j_done", j_out, 0);
        chk("k_done", k_out, 0);
      end
    end
    @(negedge clk);
    chk("ready_after", cmd_ready, 1);
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);
    chk("q_after", q, mq);
  endtask

  initial begin
    logic [2:0] rop;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0; cmd_cnt = '0;
    mq = '0;
    repeat (2) @(negedge clk);
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_j", j_out, 0);
    chk("rst_k", k_out, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed sequence from the test plan.
    run_cmd(3'd3, 8'hA5, 8'd0);
    chk("load_a5", q, 8'hA5);
    run_cmd(3'd4, 8'h0F, 8'd0);
    chk("toggle", q, 8'hAA);
    run_cmd(3'd1, 8'h00, 8'd0);
    chk("clear", q, 8'h00);
    run_cmd(3'd2, 8'h00, 8'd0);
    chk("set", q, 8'hFF);
    run_cmd(3'd3, 8'hFE, 8'd0);
    run_cmd(3'd5, 8'h00, 8'd3);
    chk("count3", q, 8'h01);
    run_cmd(3'd5, 8'h00, 8'd0);
    chk("count0", q, 8'h01);
    run_cmd(3'd3, 8'hFF, 8'd0);
    run_cmd(3'd5, 8'h00, 8'd1);
    chk("wrap_up", q, 8'h00);
    run_cmd(3'd3, 8'h01, 8'd0);
    run_cmd(3'd6, 8'h00, 8'd2);
    chk("op6", q, DOWN ? 8'hFF : 8'h01);
    run_cmd(3'd7, 8'h5A, 8'd4);

    // Held valid during a long COUNT, then reset mid-RUN.
    cmd_valid = 1'b1; cmd_op = 3'd5; cmd_cnt = 8'd10; cmd_arg = 8'h00;
    @(posedge clk);
    #1 cmd_op = 3'd3; cmd_arg = 8'h33;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      chk("hold_ready", cmd_ready, 0);
      chk("hold_q", q, mq);
      chk("hold_done", done, 0);
      mq = mq + 1'b1;
    end
    @(negedge clk);
    chk("run4_q", q, mq);
    rst_n = 1'b0;
    #1;
    chk("abort_q", q, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    mq = '0;
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_ready", cmd_ready, 1);
      chk("post_rst_done", done, 0);
      chk("post_rst_q", q, 0);
    end

    // Random commands.
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      run_cmd(rop, W'($urandom), counts(rop) ? CW'($urandom_range(0, 6)) : CW'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
